// File: rtl/mmc3_irq_controller_if.sv
// CPU write bus, PPU A12 input and IRQ outputs of the MMC3 scanline IRQ block.
// The master side is the console/bench; the slave side is the controller.
interface mmc3_irq_controller_if;
  logic        romsel;
  logic        cpu_rw_in;
  logic [14:0] cpu_addr_in;
  logic [7:0]  cpu_data_in;
  logic        ppu_a12;
  logic        irq;
  logic [7:0]  irq_counter;
  logic        irq_enabled;

  modport master (
    output romsel, cpu_rw_in, cpu_addr_in, cpu_data_in, ppu_a12,
    input  irq, irq_counter, irq_enabled
  );

  modport slave (
    input  romsel, cpu_rw_in, cpu_addr_in, cpu_data_in, ppu_a12,
    output irq, irq_counter, irq_enabled
  );
endinterface

// File: rtl/mmc3_irq_controller.sv
// MMC3 scanline IRQ: filtered PPU A12 rising edges clock an 8-bit down-counter
// that reloads from a latch and raises a sticky, registered active-low IRQ.
module mmc3_irq_controller #(
  parameter int A12_LOW_CYCLES = 3,
  parameter bit MMC3_OLD_IRQ   = 1'b0
) (
  input  logic                   m2,
  input  logic                   reset,
  mmc3_irq_controller_if.slave   bus
);

  localparam logic [2:0] LOW_MIN = 3'(A12_LOW_CYCLES);

  logic       r_a12_meta;
  logic       r_a12_s;
  logic       r_a12_prev;
  logic [2:0] r_low_cnt;
  logic [7:0] r_latch;
  logic [7:0] r_counter;
  logic       r_reload;
  logic       r_enable;
  logic       r_pending;
  logic       r_irq;

  logic       w_strobe;
  logic       w_wr_latch;
  logic       w_wr_reload;
  logic       w_wr_disable;
  logic       w_wr_enable;
  logic       w_event;
  logic [7:0] w_latch_nxt;
  logic [7:0] w_counter_nxt;
  logic       w_reload_nxt;
  logic       w_enable_nxt;
  logic       w_pending_nxt;

  // Register writes are applied after the clock event so that a colliding
  // write overrides the event, while the event itself sees the old registers.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
    w_strobe      = ~bus.romsel & ~bus.cpu_rw_in;
    w_wr_latch    = w_strobe & (bus.cpu_addr_in[14:13] == 2'b10) & ~bus.cpu_addr_in[0];
    w_wr_reload   = w_strobe & (bus.cpu_addr_in[14:13] == 2'b10) &  bus.cpu_addr_in[0];
    w_wr_disable  = w_strobe & (bus.cpu_addr_in[14:13] == 2'b11) & ~bus.cpu_addr_in[0];
    w_wr_enable   = w_strobe & (bus.cpu_addr_in[14:13] == 2'b11) &  bus.cpu_addr_in[0];
    w_event       = r_a12_s & ~r_a12_prev & (r_low_cnt >= LOW_MIN);
    w_latch_nxt   = r_latch;
    w_counter_nxt = r_counter;
    w_reload_nxt  = r_reload;
    w_enable_nxt  = r_enable;
    w_pending_nxt = r_pending;

    if (w_event) begin
      if (r_counter == 8'd0 || r_reload) begin
        w_counter_nxt = r_latch;
        w_reload_nxt  = 1'b0;
      end else begin
        w_counter_nxt = r_counter - 8'd1;
      end
      // The old revision only fires on a 1->0 decrement or a forced reload.
      if (w_counter_nxt == 8'd0 && r_enable &&
          (!MMC3_OLD_IRQ || r_reload || r_counter == 8'd1)) begin
        w_pending_nxt = 1'b1;
      end
    end

    if (w_wr_reload) begin
      w_counter_nxt = 8'd0;
      w_reload_nxt  = 1'b1;
      w_pending_nxt = r_pending;
    end
    if (w_wr_latch) begin
      w_latch_nxt = bus.cpu_data_in;
    end
    if (w_wr_disable) begin
      w_enable_nxt  = 1'b0;
      w_pending_nxt = 1'b0;
    end
    if (w_wr_enable) begin
      w_enable_nxt = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge m2) begin
    if (reset) begin
      r_a12_meta <= 1'b0;
      r_a12_s    <= 1'b0;
      r_a12_prev <= 1'b0;
      r_low_cnt  <= 3'd0;
      r_latch    <= 8'd0;
      r_counter  <= 8'd0;
      r_reload   <= 1'b0;
      r_enable   <= 1'b0;
      r_pending  <= 1'b0;
      r_irq      <= 1'b1;
    end else begin
      r_a12_meta <= bus.ppu_a12;
      r_a12_s    <= r_a12_meta;
      r_a12_prev <= r_a12_s;
      if (r_a12_s) begin
        r_low_cnt <= 3'd0;
      end else if (r_low_cnt != 3'd7) begin
        r_low_cnt <= r_low_cnt + 3'd1;
      end
      r_latch   <= w_latch_nxt;
      r_counter <= w_counter_nxt;
      r_reload  <= w_reload_nxt;
      r_enable  <= w_enable_nxt;
      r_pending <= w_pending_nxt;
      r_irq     <= ~r_pending;
    end
  end

  assign bus.irq         = r_irq;
  assign bus.irq_counter = r_counter;
  assign bus.irq_enabled = r_enable;

endmodule

// File: tb/tb_mmc3_irq_controller.sv
// Scoreboard bench: two controllers (new and old IRQ rule) share one stimulus
// stream; a history-based reference model predicts every post-edge output.
module tb_mmc3_irq_controller;

  logic m2 = 1'b0;
  logic reset;
  always #5 m2 = ~m2;

  mmc3_irq_controller_if bus_new ();
  mmc3_irq_controller_if bus_old ();

  mmc3_irq_controller #(.A12_LOW_CYCLES(3), .MMC3_OLD_IRQ(1'b0)) dut_new (
    .m2(m2), .reset(reset), .bus(bus_new)
  );
  mmc3_irq_controller #(.A12_LOW_CYCLES(3), .MMC3_OLD_IRQ(1'b1)) dut_old (
    .m2(m2), .reset(reset), .bus(bus_old)
  );

  typedef struct packed {
    logic [7:0] counter;
    logic       enabled;
    logic       irq_new;
    logic       irq_old;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec     = 0;
  int   n_miscmp  = 0;

  // Reference model state in register terms of the programmer's view.
  int   m_latch, m_counter;
  bit   m_reload, m_enable, m_pend_new, m_pend_old, m_irq_new, m_irq_old;
  bit   hist[$];   // raw A12 level sampled at each edge since reset
  bit   cur_a12;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_vec++;
    if (actual !== expected) begin
      n_miscmp++;
      $display("FAIL %s: dut=%0d model=%0d at %0t", name, actual, expected, $time);
    end
  endtask

  // A12 seen by the counter lags the pin by two samples; an event needs a
  // high sample preceded by a run of at least 3 low samples.
  task automatic model_step(input bit rst, input bit romsel, input bit rw,
                            input logic [14:0] addr, input logic [7:0] data, input bit a12);
    bit   ev, strobe, c000, c001, e000, e001;
    int   n, run, old_cnt, new_cnt;
    bit   old_rl;
    if (rst) begin
      m_latch = 0; m_counter = 0; m_reload = 0; m_enable = 0;
      m_pend_new = 0; m_pend_old = 0; m_irq_new = 1; m_irq_old = 1;
      hist = '{1'b0, 1'b0};
      return;
    end
    hist.push_back(a12);
    if (hist.size() > 16) void'(hist.pop_front());
    n  = hist.size();
    ev = 1'b0;
    if (n >= 4 && hist[n-3] && !hist[n-4]) begin
      run = 0;
      for (int i = n - 4; i >= 0 && !hist[i]; i--) run++;
      ev = (run >= 3);
    end
    m_irq_new = !m_pend_new;
    m_irq_old = !m_pend_old;

    strobe = !romsel && !rw;
    c000 = strobe && addr[14:13] == 2'b10 && !addr[0];
    c001 = strobe && addr[14:13] == 2'b10 &&  addr[0];
    e000 = strobe && addr[14:13] == 2'b11 && !addr[0];
    e001 = strobe && addr[14:13] == 2'b11 &&  addr[0];

    old_cnt = m_counter;
    old_rl  = m_reload;
    if (ev && !c001) begin
      if (old_cnt == 0 || old_rl) begin
        new_cnt  = m_latch;
        m_reload = 0;
      end else begin
        new_cnt = old_cnt - 1;
      end
      m_counter = new_cnt;
      if (new_cnt == 0 && m_enable) begin
        m_pend_new = 1;
        if (old_rl || old_cnt == 1) m_pend_old = 1;
      end
    end
    if (c001) begin
      m_counter = 0;
      m_reload  = 1;
    end
    if (c000) m_latch = data;
    if (e000) begin
      m_enable = 0; m_pend_new = 0; m_pend_old = 0;
    end
    if (e001) m_enable = 1;
  endtask

  task automatic drive_cycle(input bit rst, input bit romsel, input bit rw,
                             input logic [14:0] addr, input logic [7:0] data, input bit a12);
    exp_t e;
    @(negedge m2);
    reset               = rst;
    bus_new.romsel      = romsel;  bus_old.romsel      = romsel;
    bus_new.cpu_rw_in   = rw;      bus_old.cpu_rw_in   = rw;
    bus_new.cpu_addr_in = addr;    bus_old.cpu_addr_in = addr;
    bus_new.cpu_data_in = data;    bus_old.cpu_data_in = data;
    bus_new.ppu_a12     = a12;     bus_old.ppu_a12     = a12;
    model_step(rst, romsel, rw, addr, data, a12);
    e.counter = 8'(m_counter);
    e.enabled = m_enable;
    e.irq_new = m_irq_new;
    e.irq_old = m_irq_old;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) drive_cycle(1'b0, 1'b1, 1'b1, 15'h0, 8'h0, cur_a12);
  endtask

  task automatic do_reset(input int cycles);
    for (int i = 0; i < cycles; i++) drive_cycle(1'b1, 1'b1, 1'b1, 15'h0, 8'h0, cur_a12);
  endtask

  task automatic wr(input logic [15:0] addr, input logic [7:0] data);
    drive_cycle(1'b0, 1'b0, 1'b0, addr[14:0], data, cur_a12);
  endtask

  task automatic pulse(input int lo, input int hi);
    cur_a12 = 1'b0;
    idle(lo);
    cur_a12 = 1'b1;
    idle(hi);
  endtask

  // Monitor: every edge carries one expected observation.
  initial begin
    exp_t e;
    forever begin
      @(posedge m2);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("counter_new", bus_new.irq_counter, e.counter);
        check("counter_old", bus_old.irq_counter, e.counter);
        check("enabled_new", bus_new.irq_enabled, e.enabled);
        check("enabled_old", bus_old.irq_enabled, e.enabled);
        check("irq_new",     bus_new.irq,         e.irq_new);
        check("irq_old",     bus_old.irq,         e.irq_old);
      end
    end
  end

  initial begin
    int          run_left;
    int          r;
    logic [1:0]  sel;
    logic [14:0] ra;
    reset = 1'b1;
    cur_a12 = 1'b0;
    bus_new.romsel = 1'b1; bus_old.romsel = 1'b1;
    bus_new.cpu_rw_in = 1'b1; bus_old.cpu_rw_in = 1'b1;
    bus_new.cpu_addr_in = '0; bus_old.cpu_addr_in = '0;
    bus_new.cpu_data_in = '0; bus_old.cpu_data_in = '0;
    bus_new.ppu_a12 = 1'b0; bus_old.ppu_a12 = 1'b0;

    do_reset(2);
    idle(4);

    // Basic count from latch 3, then acknowledge and recount.
    wr(16'hC000, 8'd3); wr(16'hC001, 8'd0); wr(16'hE001, 8'd0);
    repeat (4) pulse(8, 8);
    idle(4);
    wr(16'hE000, 8'd0); idle(2);
    wr(16'hE001, 8'd0);
    repeat (4) pulse(8, 8);
    idle(4);

    // Low-time filter: 2-cycle lows ignored, 3-cycle lows counted.
    wr(16'hE000, 8'd0);
    wr(16'hC000, 8'd10); wr(16'hC001, 8'd0);
    pulse(8, 4);
    repeat (3) pulse(2, 4);
    pulse(3, 4);
    pulse(8, 4);

    // Latch 0: new rule fires every event, old rule only the first.
    wr(16'hC000, 8'd0); wr(16'hC001, 8'd0); wr(16'hE001, 8'd0);
    repeat (3) begin
      pulse(8, 6);
      idle(2);
      wr(16'hE000, 8'd0);
      wr(16'hE001, 8'd0);
    end

    // $C001 colliding with a clock event at counter 5.
    wr(16'hC000, 8'd5); wr(16'hC001, 8'd0);
    pulse(8, 4);
    cur_a12 = 1'b0; idle(8);
    cur_a12 = 1'b1; idle(2);
    wr(16'hC001, 8'd0);
    idle(3);
    pulse(8, 4);

    // Reset with pending set and counter 7.
    wr(16'hC000, 8'd0); wr(16'hC001, 8'd0); wr(16'hE001, 8'd0);
    pulse(8, 4);
    wr(16'hC000, 8'd7); wr(16'hC001, 8'd0);
    pulse(8, 4);
    do_reset(1);
    idle(6);

    // Randomized traffic with small latch values so zero is reached often.
    run_left = 0;
    for (int k = 0; k < 3000; k++) begin
      if (run_left == 0) begin
        cur_a12  = ~cur_a12;
        run_left = $urandom_range(1, 9);
      end
      run_left--;
      r = $urandom_range(0, 99);
      if (r < 2) begin
        do_reset(1);
      end else if (r < 14) begin
        sel = 2'($urandom_range(0, 3));
        ra  = 15'($urandom);
        ra[14:13] = {1'b1, sel[1]};
        ra[0]     = sel[0];
        drive_cycle(1'b0, 1'b0, 1'b0, ra, 8'($urandom_range(0, 6)), cur_a12);
      end else if (r < 18) begin
        drive_cycle(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    15'($urandom), 8'($urandom), cur_a12);
      end else begin
        idle(1);
      end
    end

    idle(2);
    @(posedge m2);
    #2;
    check("queue_drain", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule
